// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - handshake and result bus for imm_gen_pipe
interface imm_gen_pipe_if #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          instruction;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     ImmExt;
  logic [2:0]           ImmType;
  logic                 illegal;
  logic [CNT_WIDTH-1:0] illegal_count;

  modport slave (
    input  flush, in_valid, instruction, out_ready,
    output in_ready, out_valid, ImmExt, ImmType, illegal, illegal_count
  );

  modport master (
    output flush, in_valid, instruction, out_ready,
    input  in_ready, out_valid, ImmExt, ImmType, illegal, illegal_count
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RISC-V immediate generator with one-entry output buffer
// Optional CSR-immediate decode enabled by defining IMM_GEN_ZICSR_EN.
module imm_gen_pipe #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  imm_gen_pipe_if.slave bus
);

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5,
    IMM_Z    = 3'd6
  } imm_type_e;

  logic [31:0]          ins;
  logic [6:0]           opcode;
  logic [2:0]           funct3;
  logic                 is_shift;
  logic [WIDTH-1:0]     shamt;
  logic [WIDTH-1:0]     dec_imm;
  imm_type_e            dec_type;
  logic                 dec_ill;
  logic                 accept;

  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     imm_q, imm_d;
  imm_type_e            type_q, type_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  assign ins      = bus.instruction;
  assign opcode   = ins[6:0];
  assign funct3   = ins[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  // RV64 shifts carry a 6-bit shamt; RV32 only 5
  assign shamt    = (WIDTH == 64) ? WIDTH'(ins[25:20]) : WIDTH'(ins[24:20]);

  always_comb begin
    dec_imm  = '0;
    dec_type = IMM_NONE;
    dec_ill  = 1'b0;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        dec_type = IMM_I;
        if (opcode == 7'b0010011 && is_shift) dec_imm = shamt;
        else                                  dec_imm = WIDTH'($signed(ins[31:20]));
      end
      7'b0011011: begin
        if (WIDTH == 64) begin
          dec_type = IMM_I;
          if (is_shift) dec_imm = WIDTH'(ins[24:20]);
          else          dec_imm = WIDTH'($signed(ins[31:20]));
        end else begin
          dec_ill = 1'b1;
        end
      end
      7'b0100011: begin
        dec_type = IMM_S;
        dec_imm  = WIDTH'($signed({ins[31:25], ins[11:7]}));
      end
      7'b1100011: begin
        dec_type = IMM_B;
        dec_imm  = WIDTH'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
      end
      7'b0110111, 7'b0010111: begin
        dec_type = IMM_U;
        dec_imm  = WIDTH'($signed({ins[31:12], 12'b0}));
      end
      7'b1101111: begin
        dec_type = IMM_J;
        dec_imm  = WIDTH'($signed({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}));
      end
      7'b0110011: ;
`ifdef IMM_GEN_ZICSR_EN
      7'b1110011: begin
        if (funct3[2] && funct3[1:0] != 2'b00) begin
          dec_type = IMM_Z;
          dec_imm  = WIDTH'(ins[19:15]);
        end
      end
`endif
      default: dec_ill = 1'b1;
    endcase
  end

  assign bus.in_ready = !bus.flush && (!valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    valid_d   = valid_q;
    imm_d     = imm_q;
    type_d    = type_q;
    illegal_d = illegal_q;
    cnt_d     = cnt_q;
    if (accept) begin
      valid_d   = 1'b1;
      imm_d     = dec_imm;
      type_d    = dec_type;
      illegal_d = dec_ill;
      if (dec_ill && cnt_q != {CNT_WIDTH{1'b1}}) cnt_d = cnt_q + 1'b1;
    end else if (bus.flush || bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q   <= 1'b0;
      imm_q     <= '0;
      type_q    <= IMM_NONE;
      illegal_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      imm_q     <= imm_d;
      type_q    <= type_d;
      illegal_q <= illegal_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.out_valid     = valid_q;
  assign bus.ImmExt        = imm_q;
  assign bus.ImmType       = type_q;
  assign bus.illegal       = illegal_q;
  assign bus.illegal_count = cnt_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized and directed bench for imm_gen_pipe against a reference model
module tb_imm_gen_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_gen_pipe_if #(.WIDTH(32), .CNT_WIDTH(8)) i32 ();
  imm_gen_pipe_if #(.WIDTH(64), .CNT_WIDTH(8)) i64 ();
  imm_gen_pipe_if #(.WIDTH(32), .CNT_WIDTH(2)) ic2 ();

  imm_gen_pipe #(.WIDTH(32), .CNT_WIDTH(8)) dut32 (.clk(clk), .rst(rst), .bus(i32));
  imm_gen_pipe #(.WIDTH(64), .CNT_WIDTH(8)) dut64 (.clk(clk), .rst(rst), .bus(i64));
  imm_gen_pipe #(.WIDTH(32), .CNT_WIDTH(2)) dutc2 (.clk(clk), .rst(rst), .bus(ic2));

  int passed = 0;
  int total  = 0;

  // Reference state: what each buffer should hold
  bit          mv;
  logic [31:0] m_imm32;
  logic [63:0] m_imm64;
  logic [2:0]  m_typ32, m_typ64;
  bit          m_ill32, m_ill64;
  int          m_cnt32, m_cnt64, m_cnt2;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Decode from the instruction-set rules as plain signed arithmetic
  task automatic ref_dec(input logic [31:0] ins, input bit w64,
                         output logic [63:0] imm, output logic [2:0] typ, output bit ill);
    longint v;
    logic [6:0] opc;
    logic [2:0] f3;
    v   = 0;
    typ = 3'd0;
    ill = 1'b0;
    opc = ins[6:0];
    f3  = ins[14:12];
    if (opc == 7'h13 || opc == 7'h03 || opc == 7'h67 || (opc == 7'h1B && w64)) begin
      typ = 3'd1;
      if ((opc == 7'h13 || opc == 7'h1B) && (f3 == 3'd1 || f3 == 3'd5))
        v = (w64 && opc == 7'h13) ? longint'(ins[25:20]) : longint'(ins[24:20]);
      else
        v = longint'(ins[30:20]) - (ins[31] ? 2048 : 0);
    end else if (opc == 7'h23) begin
      typ = 3'd2;
      v = longint'(ins[30:25]) * 32 + longint'(ins[11:7]) - (ins[31] ? 2048 : 0);
    end else if (opc == 7'h63) begin
      typ = 3'd3;
      v = longint'(ins[7]) * 2048 + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2
          - (ins[31] ? 4096 : 0);
    end else if (opc == 7'h37 || opc == 7'h17) begin
      typ = 3'd4;
      v = longint'(ins[30:12]) * 4096 - (ins[31] ? 64'sh80000000 : 64'sh0);
    end else if (opc == 7'h6F) begin
      typ = 3'd5;
      v = longint'(ins[19:12]) * 4096 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2
          - (ins[31] ? 1048576 : 0);
    end else if (opc == 7'h33) begin
      v = 0;
`ifdef IMM_GEN_ZICSR_EN
    end else if (opc == 7'h73) begin
      if (f3 >= 3'd5) begin
        typ = 3'd6;
        v = longint'(ins[19:15]);
      end
`endif
    end else begin
      ill = 1'b1;
    end
    imm = v;
  endtask

  task automatic model_reset();
    mv = 0; m_imm32 = '0; m_imm64 = '0; m_typ32 = '0; m_typ64 = '0;
    m_ill32 = 0; m_ill64 = 0; m_cnt32 = 0; m_cnt64 = 0; m_cnt2 = 0;
  endtask

  task automatic check_outputs(input string where);
    chk({where, ":v32"},  64'(i32.out_valid), 64'(mv));
    chk({where, ":v64"},  64'(i64.out_valid), 64'(mv));
    chk({where, ":vc2"},  64'(ic2.out_valid), 64'(mv));
    chk({where, ":imm32"}, 64'(i32.ImmExt), 64'(m_imm32));
    chk({where, ":imm64"}, i64.ImmExt, m_imm64);
    chk({where, ":immc2"}, 64'(ic2.ImmExt), 64'(m_imm32));
    chk({where, ":typ32"}, 64'(i32.ImmType), 64'(m_typ32));
    chk({where, ":typ64"}, 64'(i64.ImmType), 64'(m_typ64));
    chk({where, ":ill32"}, 64'(i32.illegal), 64'(m_ill32));
    chk({where, ":ill64"}, 64'(i64.illegal), 64'(m_ill64));
    chk({where, ":cnt32"}, 64'(i32.illegal_count), 64'(m_cnt32));
    chk({where, ":cnt64"}, 64'(i64.illegal_count), 64'(m_cnt64));
    chk({where, ":cntc2"}, 64'(ic2.illegal_count), 64'(m_cnt2));
  endtask

  task automatic drive(input bit iv, input logic [31:0] ins, input bit ordy, input bit fl);
    i32.in_valid = iv; i32.instruction = ins; i32.out_ready = ordy; i32.flush = fl;
    i64.in_valid = iv; i64.instruction = ins; i64.out_ready = ordy; i64.flush = fl;
    ic2.in_valid = iv; ic2.instruction = ins; ic2.out_ready = ordy; ic2.flush = fl;
  endtask

  task automatic step(input string where, input bit iv, input logic [31:0] ins,
                      input bit ordy, input bit fl);
    bit          rdy;
    logic [63:0] t64;
    bit          ill;
    @(negedge clk);
    drive(iv, ins, ordy, fl);
    #1;
    rdy = !fl && (!mv || ordy);
    chk({where, ":rdy32"}, 64'(i32.in_ready), 64'(rdy));
    chk({where, ":rdy64"}, 64'(i64.in_ready), 64'(rdy));
    chk({where, ":rdyc2"}, 64'(ic2.in_ready), 64'(rdy));
    if (iv && rdy) begin
      mv = 1;
      ref_dec(ins, 1'b0, t64, m_typ32, ill);
      m_imm32 = t64[31:0];
      m_ill32 = ill;
      if (ill) begin
        m_cnt32 = (m_cnt32 < 255) ? m_cnt32 + 1 : 255;
        m_cnt2  = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
      end
      ref_dec(ins, 1'b1, m_imm64, m_typ64, ill);
      m_ill64 = ill;
      if (ill) m_cnt64 = (m_cnt64 < 255) ? m_cnt64 + 1 : 255;
    end else if (fl || ordy) begin
      mv = 0;
    end
    @(posedge clk);
    #1;
    check_outputs(where);
  endtask

  logic [6:0] opcs [16] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17,
                            7'h6F, 7'h33, 7'h73, 7'h7F, 7'h00, 7'h0F, 7'h5B, 7'h13};

  initial begin
    logic [31:0] r;
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    model_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    step("addi",   1, 32'hFF638293, 1, 0);
    chk("addi_val", 64'(i32.ImmExt), 64'hFFFFFFF6);
    step("drain",  0, 32'h0, 1, 0);
    step("lui",    1, 32'h80000037, 1, 0);
    chk("lui64_val", i64.ImmExt, 64'hFFFFFFFF80000000);
    step("slli",   1, 32'h03F01013, 1, 0);
    chk("slli64_val", i64.ImmExt, 64'd63);
    step("branch", 1, 32'h80018063, 1, 0);
    chk("b_val", i64.ImmExt, 64'hFFFFFFFFFFFFF000);
    step("jal",    1, 32'h7FFFF0EF, 1, 0);
    chk("j_val", 64'(i32.ImmExt), 64'd1048574);
    step("addiw",  1, 32'h0050809B, 1, 0);

    step("bp_load", 1, 32'h00C12083, 0, 0);
    for (int k = 0; k < 3; k++) step("bp_hold", 1, 32'hFFF00113, 0, 0);
    step("bp_rel",  1, 32'hFFF00113, 1, 0);
    step("bp_out",  0, 32'h0, 1, 0);

    for (int k = 0; k < 5; k++) step("illegal", 1, 32'h0000007F, 1, 0);
    chk("sat_c2", 64'(ic2.illegal_count), 64'd3);
    step("flush",  1, 32'h0000007F, 1, 1);
    step("csr",    1, 32'h3001D073, 1, 0);
    step("rtype",  1, 32'h00B50533, 1, 0);

    step("async_load", 1, 32'hABCDE037, 0, 0);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 400; k++) begin
      r = $urandom();
      step("rand", $urandom_range(0, 3) != 0, {r[31:7], opcs[$urandom_range(0, 15)]},
           $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
